// File: rtl/render_command_queue.sv
// render_command_queue: committed-list byte FIFO feeding the renderer's one-byte pull interface.
// Ports: i_master_clk/i_reset (async, active-high); producer i_write_data/i_write_strobe/
//   i_write_commit/i_clear with status o_write_full/o_write_level/o_list_ready; consumer
//   i_queue_request answered one cycle later by o_queue_data+o_queue_data_valid or o_queue_eof.
// Option: define RENDER_QUEUE_OVERFLOW_EN to add the sticky o_write_overflow drop flag.
module render_command_queue #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  i_master_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_write_data,
  input  logic                  i_write_strobe,
  input  logic                  i_write_commit,
  input  logic                  i_clear,
  output logic                  o_write_full,
  output logic [DEPTH_LOG2:0]   o_write_level,
  output logic                  o_list_ready,
  input  logic                  i_queue_request,
  output logic [7:0]            o_queue_data,
  output logic                  o_queue_data_valid,
  output logic                  o_queue_eof
`ifdef RENDER_QUEUE_OVERFLOW_EN
  ,output logic                 o_write_overflow
`endif
);
  localparam int AW = DEPTH_LOG2 + 1;
  localparam logic [AW-1:0] CAP = AW'(1) << DEPTH_LOG2;
  typedef enum logic {IDLE, RESP} state_t;
  logic [7:0] mem [2**DEPTH_LOG2];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, cm_q, cm_d, lvl_q, lvl_d;
  logic full_q, full_d, ready_q, ready_d, hit_q, hit_d, full, push, pop;
  logic [7:0] rdata_q, hold_q, hold_d;
  state_t state_q, state_d;
  always_comb begin
    full    = (wr_q - rd_q) == CAP;
    push    = i_write_strobe && !full && !i_clear;
    // avail is judged on the pre-commit pointer, so a same-cycle commit cannot serve this request
    pop     = i_queue_request && (cm_q != rd_q) && !i_clear;
    wr_d    = i_clear ? '0 : wr_q + AW'(push);
    rd_d    = i_clear ? '0 : rd_q + AW'(pop);
    cm_d    = i_clear ? '0 : i_write_commit ? wr_d : cm_q;
    lvl_d   = wr_d - rd_d;
    full_d  = lvl_d == CAP;
    ready_d = cm_d != rd_d;
    state_d = (i_queue_request && !i_clear) ? RESP : IDLE;
    hit_d   = pop;
    // remembers the last delivered byte so the data output holds between responses
    hold_d  = (state_q == RESP && hit_q) ? rdata_q : hold_q;
  end
  always_ff @(posedge i_master_clk) begin
    if (push) mem[wr_q[DEPTH_LOG2-1:0]] <= i_write_data;
    if (pop) rdata_q <= mem[rd_q[DEPTH_LOG2-1:0]];
  end
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cm_q    <= '0;
      lvl_q   <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      hold_q  <= '0;
      state_q <= IDLE;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cm_q    <= cm_d;
      lvl_q   <= lvl_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
      hold_q  <= hold_d;
      state_q <= state_d;
    end
  end
  assign o_write_full       = full_q;
  assign o_write_level      = lvl_q;
  assign o_list_ready       = ready_q;
  assign o_queue_data_valid = state_q == RESP && hit_q;
  assign o_queue_eof        = state_q == RESP && !hit_q;
  assign o_queue_data       = o_queue_data_valid ? rdata_q : hold_q;
`ifdef RENDER_QUEUE_OVERFLOW_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = i_clear ? 1'b0 : (ovf_q || (i_write_strobe && full));
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign o_write_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_render_command_queue.sv
// tb_render_command_queue: randomized and directed checks of render_command_queue against a queue-based model.
module tb_render_command_queue;
  localparam int DL = 9;
  localparam int DEPTH = 1 << DL;
  logic clk = 1'b0, i_reset = 1'b1;
  logic [7:0] i_write_data = '0;
  logic i_write_strobe = 0, i_write_commit = 0, i_clear = 0, i_queue_request = 0;
  logic o_write_full, o_list_ready, o_queue_data_valid, o_queue_eof;
  logic [DL:0] o_write_level;
  logic [7:0] o_queue_data;
`ifdef RENDER_QUEUE_OVERFLOW_EN
  logic o_write_overflow;
`endif
  int checks = 0, passes = 0;
  render_command_queue #(.DEPTH_LOG2(DL)) dut (
    .i_master_clk(clk), .i_reset(i_reset), .i_write_data(i_write_data),
    .i_write_strobe(i_write_strobe), .i_write_commit(i_write_commit), .i_clear(i_clear),
    .o_write_full(o_write_full), .o_write_level(o_write_level), .o_list_ready(o_list_ready),
    .i_queue_request(i_queue_request), .o_queue_data(o_queue_data),
    .o_queue_data_valid(o_queue_data_valid), .o_queue_eof(o_queue_eof)
`ifdef RENDER_QUEUE_OVERFLOW_EN
    , .o_write_overflow(o_write_overflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
  endtask
  // model: every stored byte in a queue; ncom counts how many of the front bytes are committed
  logic [7:0] q[$];
  int ncom;
  logic e_valid, e_eof, e_ovf, m_acc;
  logic [7:0] e_data;
  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      q.delete();
      ncom = 0; e_valid = 0; e_eof = 0; e_ovf = 0; e_data = '0;
    end else begin
      e_valid = 0;
      e_eof = 0;
      if (i_clear) begin
        q.delete();
        ncom = 0;
        e_ovf = 0;
      end else begin
        m_acc = q.size() < DEPTH;
        if (i_queue_request) begin
          if (ncom > 0) begin
            e_data = q.pop_front();
            ncom--;
            e_valid = 1;
          end else e_eof = 1;
        end
        if (i_write_strobe) begin
          if (m_acc) q.push_back(i_write_data);
          else e_ovf = 1;
        end
        if (i_write_commit) ncom = q.size();
      end
    end
  end
  always @(negedge clk) begin
    chk("cmp_valid", {31'b0, o_queue_data_valid}, {31'b0, e_valid});
    chk("cmp_eof", {31'b0, o_queue_eof}, {31'b0, e_eof});
    chk("cmp_data", {24'b0, o_queue_data}, {24'b0, e_data});
    chk("cmp_level", {22'b0, o_write_level}, q.size());
    chk("cmp_full", {31'b0, o_write_full}, {31'b0, q.size() == DEPTH});
    chk("cmp_ready", {31'b0, o_list_ready}, {31'b0, ncom > 0});
`ifdef RENDER_QUEUE_OVERFLOW_EN
    chk("cmp_ovf", {31'b0, o_write_overflow}, {31'b0, e_ovf});
`endif
  end
  task automatic cyc(logic [7:0] d, logic s, logic c, logic cl, logic r);
    @(negedge clk);
    i_write_data = d; i_write_strobe = s; i_write_commit = c; i_clear = cl; i_queue_request = r;
  endtask
  task automatic settle;
    @(posedge clk);
    #1;
  endtask
  task automatic req_data(string n, logic [7:0] exp);
    cyc(0, 0, 0, 0, 1);
    settle;
    chk({n, "_valid"}, {31'b0, o_queue_data_valid}, 1);
    chk({n, "_data"}, {24'b0, o_queue_data}, {24'b0, exp});
  endtask
  task automatic req_eof(string n);
    cyc(0, 0, 0, 0, 1);
    settle;
    chk({n, "_eof"}, {31'b0, o_queue_eof}, 1);
    chk({n, "_valid"}, {31'b0, o_queue_data_valid}, 0);
  endtask
  initial begin
    logic [7:0] abc [3];
    abc = '{8'hA1, 8'hB2, 8'hC3};
    repeat (2) @(negedge clk);
    chk("rst_level", {22'b0, o_write_level}, 0);
    chk("rst_data", {24'b0, o_queue_data}, 0);
    i_reset = 0;
    req_eof("empty");
    chk("empty_ready", {31'b0, o_list_ready}, 0);
    cyc(8'hA1, 1, 0, 0, 0);
    cyc(8'hB2, 1, 0, 0, 0);
    cyc(8'hC3, 1, 1, 0, 0);
    settle;
    chk("abc_level", {22'b0, o_write_level}, 3);
    chk("abc_ready", {31'b0, o_list_ready}, 1);
    for (int i = 0; i < 3; i++) req_data("abc", abc[i]);
    req_eof("abc_end");
    chk("abc_level0", {22'b0, o_write_level}, 0);
    cyc(8'h55, 1, 0, 0, 0);
    req_eof("uncommitted");
    cyc(0, 0, 1, 0, 0);
    req_data("committed", 8'h55);
    for (int i = 0; i < DEPTH; i++) cyc(8'(i), 1, i == DEPTH - 1, 0, 0);
    settle;
    chk("fill_full", {31'b0, o_write_full}, 1);
    chk("fill_level", {22'b0, o_write_level}, DEPTH);
    cyc(8'hEE, 1, 0, 0, 0);
    settle;
    chk("drop_level", {22'b0, o_write_level}, DEPTH);
`ifdef RENDER_QUEUE_OVERFLOW_EN
    chk("drop_ovf", {31'b0, o_write_overflow}, 1);
`endif
    for (int i = 0; i < DEPTH; i++) req_data("drain", 8'(i));
    cyc(0, 0, 0, 0, 0);
    settle;
    chk("drain_full", {31'b0, o_write_full}, 0);
    chk("drain_level", {22'b0, o_write_level}, 0);
    for (int i = 0; i < 10; i++) cyc(8'(8'h30 + i), 1, i == 9, 0, 0);
    for (int i = 0; i < 10; i++) req_data("wrap", 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) cyc(8'(8'h60 + i), 1, i == 4, 0, 0);
    cyc(8'h77, 1, 0, 0, 1);
    settle;
    chk("rw_level", {22'b0, o_write_level}, 5);
    chk("rw_data", {24'b0, o_queue_data}, 8'h60);
    cyc(0, 0, 0, 1, 1);
    settle;
    chk("clr_valid", {31'b0, o_queue_data_valid}, 0);
    chk("clr_eof", {31'b0, o_queue_eof}, 0);
    chk("clr_level", {22'b0, o_write_level}, 0);
`ifdef RENDER_QUEUE_OVERFLOW_EN
    chk("clr_ovf", {31'b0, o_write_overflow}, 0);
`endif
    for (int i = 0; i < 20; i++) cyc(8'(8'h80 + i), 1, i == 19, 0, 0);
    for (int i = 0; i < 5; i++) req_data("pre_rst", 8'(8'h80 + i));
    i_queue_request = 0;
    i_reset = 1;
    #1;
    chk("arst_valid", {31'b0, o_queue_data_valid}, 0);
    chk("arst_data", {24'b0, o_queue_data}, 0);
    chk("arst_level", {22'b0, o_write_level}, 0);
    chk("arst_ready", {31'b0, o_list_ready}, 0);
    @(negedge clk);
    i_reset = 0;
    req_eof("post_rst");
    for (int i = 0; i < 4000; i++)
      cyc(8'($urandom), $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 10,
          $urandom_range(0, 999) < 5, $urandom_range(0, 99) < 50);
    cyc(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
